// File: rtl/bp_mem_cmd_rr_arbiter_if.sv
// Bundle of the two requester ports, the shared memory port and the
// in-flight count for the two-way BedRock lite memory arbiter.
// The slave modport is the arbiter's view. The master modport is the
// view of the environment that surrounds it: the requesters plus memory.
interface bp_mem_cmd_rr_arbiter_if #(
    parameter int msg_width_p = 64,
    parameter int els_p       = 4
);
    localparam int cnt_width_lp = $clog2(els_p + 1);

    logic [msg_width_p-1:0]  mem_cmd0_i;
    logic                    mem_cmd0_v_i;
    logic                    mem_cmd0_ready_and_o;
    logic [msg_width_p-1:0]  mem_cmd1_i;
    logic                    mem_cmd1_v_i;
    logic                    mem_cmd1_ready_and_o;

    logic [msg_width_p-1:0]  mem_cmd_o;
    logic                    mem_cmd_v_o;
    logic                    mem_cmd_ready_and_i;

    logic [msg_width_p-1:0]  mem_resp_i;
    logic                    mem_resp_v_i;
    logic                    mem_resp_ready_and_o;

    logic [msg_width_p-1:0]  mem_resp0_o;
    logic                    mem_resp0_v_o;
    logic                    mem_resp0_ready_and_i;
    logic [msg_width_p-1:0]  mem_resp1_o;
    logic                    mem_resp1_v_o;
    logic                    mem_resp1_ready_and_i;

    logic [cnt_width_lp-1:0] outstanding_o;

    modport slave (
        input  mem_cmd0_i, mem_cmd0_v_i, mem_cmd1_i, mem_cmd1_v_i,
        output mem_cmd0_ready_and_o, mem_cmd1_ready_and_o,
        output mem_cmd_o, mem_cmd_v_o,
        input  mem_cmd_ready_and_i,
        input  mem_resp_i, mem_resp_v_i,
        output mem_resp_ready_and_o,
        output mem_resp0_o, mem_resp0_v_o, mem_resp1_o, mem_resp1_v_o,
        input  mem_resp0_ready_and_i, mem_resp1_ready_and_i,
        output outstanding_o
    );

    modport master (
        output mem_cmd0_i, mem_cmd0_v_i, mem_cmd1_i, mem_cmd1_v_i,
        input  mem_cmd0_ready_and_o, mem_cmd1_ready_and_o,
        input  mem_cmd_o, mem_cmd_v_o,
        output mem_cmd_ready_and_i,
        output mem_resp_i, mem_resp_v_i,
        input  mem_resp_ready_and_o,
        input  mem_resp0_o, mem_resp0_v_o, mem_resp1_o, mem_resp1_v_o,
        output mem_resp0_ready_and_i, mem_resp1_ready_and_i,
        input  outstanding_o
    );
endinterface

// File: rtl/bp_mem_cmd_rr_arbiter.sv
// Two-requester round-robin arbiter that shares one BedRock lite memory
// command/response channel. A 1-bit in-order ID FIFO remembers who issued
// each command, and each returning response is steered to that requester.
// Memory must answer in command order. At most els_p commands are in flight.
module bp_mem_cmd_rr_arbiter #(
    parameter int  msg_width_p  = 64,
    parameter int  els_p        = 4,
    localparam int cnt_width_lp = $clog2(els_p + 1)
) (
    input logic                   clk_i,
    input logic                   reset_i,
    bp_mem_cmd_rr_arbiter_if.slave bus
);
    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
    localparam logic [cnt_width_lp-1:0] els_cnt_lp  = cnt_width_lp'(els_p);

    logic                    last_r;
    logic                    lock_r;
    logic                    lock_id_r;
    logic [els_p-1:0]        id_mem_r;
    logic [ptr_width_lp-1:0] rptr_r;
    logic [ptr_width_lp-1:0] wptr_r;
    logic [cnt_width_lp-1:0] cnt_r;

    logic                    full;
    logic                    empty;
    logic                    head_id;
    logic                    grant_id;
    logic                    grant_v;
    logic                    cmd_v;
    logic                    cmd_hs;
    logic                    resp_ok;
    logic                    resp_ready;
    logic                    resp_hs;
    logic [msg_width_p-1:0]  cmd_sel;

    // Pointers wrap explicitly so that a depth which is not a power of two works.
    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + ptr_width_lp'(1);
    endfunction

    // Full and empty come from registered state only. A pop in this cycle
    // does not free a slot for a push in the same cycle.
    assign full    = (cnt_r == els_cnt_lp);
    assign empty   = (cnt_r == '0);
    assign head_id = id_mem_r[rptr_r];

    // Grant selection: a locked grant first, then alternate on a tie, else the lone requester.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        grant_id = 1'b0;
        grant_v  = 1'b0;
        if (lock_r) begin
            grant_id = lock_id_r;
            grant_v  = lock_id_r ? bus.mem_cmd1_v_i : bus.mem_cmd0_v_i;
        end else if (bus.mem_cmd0_v_i && bus.mem_cmd1_v_i) begin
            grant_id = ~last_r;
            grant_v  = 1'b1;
        end else if (bus.mem_cmd1_v_i) begin
            grant_id = 1'b1;
            grant_v  = 1'b1;
        end else if (bus.mem_cmd0_v_i) begin
            grant_id = 1'b0;
            grant_v  = 1'b1;
        end
    end

    // Outputs are qualified with reset_i so they drop at once when reset asserts,
    // without waiting for a clock edge. No ready input feeds any valid output.
    assign cmd_sel                  = grant_id ? bus.mem_cmd1_i : bus.mem_cmd0_i;
    assign cmd_v                    = grant_v & ~full & ~reset_i;
    assign cmd_hs                   = cmd_v & bus.mem_cmd_ready_and_i;
    assign bus.mem_cmd_o            = cmd_sel;
    assign bus.mem_cmd_v_o          = cmd_v;
    assign bus.mem_cmd0_ready_and_o = cmd_v & ~grant_id & bus.mem_cmd_ready_and_i;
    assign bus.mem_cmd1_ready_and_o = cmd_v &  grant_id & bus.mem_cmd_ready_and_i;

    assign resp_ok                  = ~empty & ~reset_i;
    assign resp_ready               = resp_ok & (head_id ? bus.mem_resp1_ready_and_i
                                                         : bus.mem_resp0_ready_and_i);
    assign resp_hs                  = bus.mem_resp_v_i & resp_ready;
    assign bus.mem_resp_ready_and_o = resp_ready;
    assign bus.mem_resp0_v_o        = bus.mem_resp_v_i & resp_ok & ~head_id;
    assign bus.mem_resp1_v_o        = bus.mem_resp_v_i & resp_ok &  head_id;
    assign bus.mem_resp0_o          = bus.mem_resp_i;
    assign bus.mem_resp1_o          = bus.mem_resp_i;
    assign bus.outstanding_o        = cnt_r;

    // Arbitration history, the lock, the FIFO pointers and the in-flight count.
    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: state registers use non-blocking assignment, so every register samples pre-edge values.
        if (reset_i) begin
            last_r    <= 1'b1;
            lock_r    <= 1'b0;
            lock_id_r <= 1'b0;
            rptr_r    <= '0;
            wptr_r    <= '0;
            cnt_r     <= '0;
        end else begin
            if (cmd_hs) begin
                last_r <= grant_id;
                lock_r <= 1'b0;
                wptr_r <= ptr_inc(wptr_r);
            end else if (cmd_v) begin
                // Offered but not accepted: keep the same requester until memory takes it.
                lock_r    <= 1'b1;
                lock_id_r <= grant_id;
            end
            if (resp_hs) begin
                rptr_r <= ptr_inc(rptr_r);
            end
            case ({cmd_hs, resp_hs})
                2'b10:   cnt_r <= cnt_r + cnt_width_lp'(1);
                2'b01:   cnt_r <= cnt_r - cnt_width_lp'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // ID storage: record the winner of each accepted command.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array is not reset. cnt_r and the pointers decide which entries are live.
        if (cmd_hs) begin
            id_mem_r[wptr_r] <= grant_id;
        end
    end

    // Memory must answer only commands that it has received.
    assert property (@(posedge clk_i) disable iff (reset_i) !(bus.mem_resp_v_i && empty))
        else $error("unexpected mem_resp");

endmodule

// File: tb/tb_bp_mem_cmd_rr_arbiter.sv
// Directed bench for bp_mem_cmd_rr_arbiter (els_p=4, 16-bit messages).
// Inputs change on the falling edge. Outputs are sampled 1 time unit later,
// well before the next rising edge.
module tb_bp_mem_cmd_rr_arbiter;
    localparam int msg_w = 16;
    localparam int els   = 4;
    localparam int cnt_w = 3;

    logic clk = 1'b0;
    logic reset_i;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bp_mem_cmd_rr_arbiter_if #(.msg_width_p(msg_w), .els_p(els)) bus ();

    bp_mem_cmd_rr_arbiter #(.msg_width_p(msg_w), .els_p(els)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    task automatic idle();
        bus.mem_cmd0_i            = '0;
        bus.mem_cmd0_v_i          = 1'b0;
        bus.mem_cmd1_i            = '0;
        bus.mem_cmd1_v_i          = 1'b0;
        bus.mem_cmd_ready_and_i   = 1'b1;
        bus.mem_resp_i            = '0;
        bus.mem_resp_v_i          = 1'b0;
        bus.mem_resp0_ready_and_i = 1'b1;
        bus.mem_resp1_ready_and_i = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_i = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        idle();
        bus.mem_cmd0_v_i = 1'b1;
        bus.mem_cmd1_v_i = 1'b1;
        bus.mem_resp_v_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (bus.mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL reset cmd_v: got %b want 0", bus.mem_cmd_v_o); end
        checks++; if (bus.mem_cmd0_ready_and_o !== 1'b0) begin errors++; $display("FAIL reset ready0: got %b want 0", bus.mem_cmd0_ready_and_o); end
        checks++; if (bus.mem_cmd1_ready_and_o !== 1'b0) begin errors++; $display("FAIL reset ready1: got %b want 0", bus.mem_cmd1_ready_and_o); end
        checks++; if (bus.mem_resp0_v_o !== 1'b0) begin errors++; $display("FAIL reset resp0_v: got %b want 0", bus.mem_resp0_v_o); end
        checks++; if (bus.mem_resp1_v_o !== 1'b0) begin errors++; $display("FAIL reset resp1_v: got %b want 0", bus.mem_resp1_v_o); end
        checks++; if (bus.mem_resp_ready_and_o !== 1'b0) begin errors++; $display("FAIL reset resp_ready: got %b want 0", bus.mem_resp_ready_and_o); end
        checks++; if (bus.outstanding_o !== 3'd0) begin errors++; $display("FAIL reset outstanding: got %0d want 0", bus.outstanding_o); end
        idle();
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        checks++; if (bus.mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL idle cmd_v: got %b want 0", bus.mem_cmd_v_o); end
    endtask

    task automatic test_single();
        logic [msg_w-1:0] d;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d = 16'hA000 + 16'(i);
            bus.mem_cmd0_v_i = 1'b1;
            bus.mem_cmd0_i   = d;
            #1;
            checks++; if (bus.mem_cmd_v_o !== 1'b1) begin errors++; $display("FAIL single cmd_v[%0d]: got %b want 1", i, bus.mem_cmd_v_o); end
            checks++; if (bus.mem_cmd_o !== d) begin errors++; $display("FAIL single cmd_o[%0d]: got %h want %h", i, bus.mem_cmd_o, d); end
            checks++; if (bus.mem_cmd0_ready_and_o !== 1'b1 || bus.mem_cmd1_ready_and_o !== 1'b0) begin errors++; $display("FAIL single ready[%0d]: got %b%b want 01", i, bus.mem_cmd1_ready_and_o, bus.mem_cmd0_ready_and_o); end
            checks++; if (bus.outstanding_o !== cnt_w'(i)) begin errors++; $display("FAIL single outstanding[%0d]: got %0d want %0d", i, bus.outstanding_o, i); end
        end
        @(negedge clk);
        bus.mem_cmd0_v_i = 1'b0;
        #1;
        checks++; if (bus.outstanding_o !== 3'd3) begin errors++; $display("FAIL single outstanding after cmds: got %0d want 3", bus.outstanding_o); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            d = 16'hB000 + 16'(i);
            bus.mem_resp_v_i = 1'b1;
            bus.mem_resp_i   = d;
            #1;
            checks++; if (bus.mem_resp0_v_o !== 1'b1 || bus.mem_resp1_v_o !== 1'b0) begin errors++; $display("FAIL single resp route[%0d]: got v1v0=%b%b want 01", i, bus.mem_resp1_v_o, bus.mem_resp0_v_o); end
            checks++; if (bus.mem_resp0_o !== d) begin errors++; $display("FAIL single resp0_o[%0d]: got %h want %h", i, bus.mem_resp0_o, d); end
            checks++; if (bus.mem_resp_ready_and_o !== 1'b1) begin errors++; $display("FAIL single resp_ready[%0d]: got %b want 1", i, bus.mem_resp_ready_and_o); end
            checks++; if (bus.outstanding_o !== cnt_w'(3 - i)) begin errors++; $display("FAIL single drain outstanding[%0d]: got %0d want %0d", i, bus.outstanding_o, 3 - i); end
        end
        @(negedge clk);
        bus.mem_resp_v_i = 1'b0;
        #1;
        checks++; if (bus.outstanding_o !== 3'd0) begin errors++; $display("FAIL single final outstanding: got %0d want 0", bus.outstanding_o); end
    endtask

    task automatic test_contention();
        int n0, n1, g, r;
        logic [msg_w-1:0] exp_cmd;
        apply_reset();
        n0 = 0;
        n1 = 0;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge clk);
            bus.mem_cmd0_v_i = (k < 6);
            bus.mem_cmd1_v_i = (k < 6);
            bus.mem_cmd0_i   = 16'hC000 + 16'(n0);
            bus.mem_cmd1_i   = 16'hC100 + 16'(n1);
            bus.mem_resp_v_i = (k >= 1);
            bus.mem_resp_i   = 16'hD000 + 16'(k);
            #1;
            g = k % 2;
            if (k < 6) begin
                exp_cmd = (g == 1) ? 16'hC100 + 16'(n1) : 16'hC000 + 16'(n0);
                checks++; if (bus.mem_cmd_o !== exp_cmd) begin errors++; $display("FAIL contention cmd_o[%0d]: got %h want %h", k, bus.mem_cmd_o, exp_cmd); end
                checks++; if (bus.mem_cmd0_ready_and_o !== (g == 0) || bus.mem_cmd1_ready_and_o !== (g == 1)) begin errors++; $display("FAIL contention grant[%0d]: got r1r0=%b%b want grant %0d", k, bus.mem_cmd1_ready_and_o, bus.mem_cmd0_ready_and_o, g); end
            end
            if (k >= 1) begin
                r = (k - 1) % 2;
                checks++; if (bus.mem_resp0_v_o !== (r == 0) || bus.mem_resp1_v_o !== (r == 1)) begin errors++; $display("FAIL contention resp route[%0d]: got v1v0=%b%b want id %0d", k, bus.mem_resp1_v_o, bus.mem_resp0_v_o, r); end
            end
            checks++; if (bus.outstanding_o !== ((k == 0) ? 3'd0 : 3'd1)) begin errors++; $display("FAIL contention outstanding[%0d]: got %0d want %0d", k, bus.outstanding_o, (k == 0) ? 0 : 1); end
            if (g == 0) n0++; else n1++;
        end
        @(negedge clk);
        idle();
        #1;
        checks++; if (bus.outstanding_o !== 3'd0) begin errors++; $display("FAIL contention final outstanding: got %0d want 0", bus.outstanding_o); end
    endtask

    task automatic test_backpressure_lock();
        logic [2:0] order;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.mem_cmd1_v_i        = 1'b1;
            bus.mem_cmd1_i          = 16'hE100;
            bus.mem_cmd0_v_i        = (c >= 1);
            bus.mem_cmd0_i          = 16'hE000;
            bus.mem_cmd_ready_and_i = (c == 4);
            #1;
            checks++; if (bus.mem_cmd_v_o !== 1'b1) begin errors++; $display("FAIL lock cmd_v[%0d]: got %b want 1", c, bus.mem_cmd_v_o); end
            checks++; if (bus.mem_cmd_o !== 16'hE100) begin errors++; $display("FAIL lock cmd_o[%0d]: got %h want e100", c, bus.mem_cmd_o); end
            checks++; if (bus.mem_cmd1_ready_and_o !== (c == 4) || bus.mem_cmd0_ready_and_o !== 1'b0) begin errors++; $display("FAIL lock ready[%0d]: got r1r0=%b%b want %b0", c, bus.mem_cmd1_ready_and_o, bus.mem_cmd0_ready_and_o, (c == 4)); end
        end
        @(negedge clk);
        bus.mem_cmd1_i = 16'hE101;
        #1;
        checks++; if (bus.mem_cmd_o !== 16'hE000 || bus.mem_cmd0_ready_and_o !== 1'b1) begin errors++; $display("FAIL lock next grant: got cmd_o=%h r0=%b want e000 1", bus.mem_cmd_o, bus.mem_cmd0_ready_and_o); end
        @(negedge clk);
        bus.mem_cmd0_v_i = 1'b0;
        #1;
        checks++; if (bus.mem_cmd_o !== 16'hE101 || bus.mem_cmd1_ready_and_o !== 1'b1) begin errors++; $display("FAIL lock follow grant: got cmd_o=%h r1=%b want e101 1", bus.mem_cmd_o, bus.mem_cmd1_ready_and_o); end
        @(negedge clk);
        idle();
        order = 3'b101;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            bus.mem_resp_v_i = 1'b1;
            #1;
            checks++; if (bus.mem_resp0_v_o !== ~order[j] || bus.mem_resp1_v_o !== order[j]) begin errors++; $display("FAIL lock resp route[%0d]: got v1v0=%b%b want id %b", j, bus.mem_resp1_v_o, bus.mem_resp0_v_o, order[j]); end
            checks++; if (bus.outstanding_o !== cnt_w'(3 - j)) begin errors++; $display("FAIL lock outstanding[%0d]: got %0d want %0d", j, bus.outstanding_o, 3 - j); end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.mem_cmd0_v_i = 1'b1;
            bus.mem_cmd0_i   = 16'hF000 + 16'(i);
            #1;
            checks++; if (bus.mem_cmd0_ready_and_o !== 1'b1 || bus.outstanding_o !== cnt_w'(i)) begin errors++; $display("FAIL full fill[%0d]: got r0=%b cnt=%0d want 1 %0d", i, bus.mem_cmd0_ready_and_o, bus.outstanding_o, i); end
        end
        @(negedge clk);
        bus.mem_cmd0_i   = 16'hF004;
        bus.mem_resp_v_i = 1'b1;
        bus.mem_resp_i   = 16'h5A00;
        #1;
        checks++; if (bus.outstanding_o !== 3'd4) begin errors++; $display("FAIL full outstanding: got %0d want 4", bus.outstanding_o); end
        checks++; if (bus.mem_cmd_v_o !== 1'b0 || bus.mem_cmd0_ready_and_o !== 1'b0) begin errors++; $display("FAIL full blocks cmd: got v=%b r0=%b want 0 0", bus.mem_cmd_v_o, bus.mem_cmd0_ready_and_o); end
        checks++; if (bus.mem_resp0_v_o !== 1'b1 || bus.mem_resp_ready_and_o !== 1'b1) begin errors++; $display("FAIL full pop: got v0=%b rdy=%b want 1 1", bus.mem_resp0_v_o, bus.mem_resp_ready_and_o); end
        @(negedge clk);
        bus.mem_resp_v_i = 1'b0;
        #1;
        checks++; if (bus.outstanding_o !== 3'd3) begin errors++; $display("FAIL full after pop: got %0d want 3", bus.outstanding_o); end
        checks++; if (bus.mem_cmd_v_o !== 1'b1 || bus.mem_cmd0_ready_and_o !== 1'b1 || bus.mem_cmd_o !== 16'hF004) begin errors++; $display("FAIL full 5th cmd: got v=%b r0=%b d=%h want 1 1 f004", bus.mem_cmd_v_o, bus.mem_cmd0_ready_and_o, bus.mem_cmd_o); end
        @(negedge clk);
        bus.mem_cmd0_v_i          = 1'b0;
        bus.mem_resp_v_i          = 1'b1;
        bus.mem_resp0_ready_and_i = 1'b0;
        #1;
        checks++; if (bus.mem_resp0_v_o !== 1'b1 || bus.mem_resp_ready_and_o !== 1'b0) begin errors++; $display("FAIL full resp stall: got v0=%b rdy=%b want 1 0", bus.mem_resp0_v_o, bus.mem_resp_ready_and_o); end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            bus.mem_resp0_ready_and_i = 1'b1;
            #1;
            checks++; if (bus.outstanding_o !== cnt_w'(4 - j) || bus.mem_resp_ready_and_o !== 1'b1) begin errors++; $display("FAIL full drain[%0d]: got cnt=%0d rdy=%b want %0d 1", j, bus.outstanding_o, bus.mem_resp_ready_and_o, 4 - j); end
        end
        @(negedge clk);
        idle();
        #1;
        checks++; if (bus.outstanding_o !== 3'd0) begin errors++; $display("FAIL full final outstanding: got %0d want 0", bus.outstanding_o); end
    endtask

    task automatic test_push_pop_wrap();
        logic [13:0] pat;
        int q[$];
        int h;
        logic p;
        pat = 14'b10110010011101;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            p = pat[k];
            bus.mem_cmd0_v_i = ~p;
            bus.mem_cmd1_v_i = p;
            bus.mem_cmd0_i   = 16'h7000 + 16'(k);
            bus.mem_cmd1_i   = 16'h7100 + 16'(k);
            bus.mem_resp_v_i = (k >= 2);
            bus.mem_resp_i   = 16'h6000 + 16'(k);
            #1;
            checks++; if (bus.mem_cmd0_ready_and_o !== ~p || bus.mem_cmd1_ready_and_o !== p) begin errors++; $display("FAIL wrap grant[%0d]: got r1r0=%b%b want id %b", k, bus.mem_cmd1_ready_and_o, bus.mem_cmd0_ready_and_o, p); end
            checks++; if (bus.outstanding_o !== ((k < 2) ? cnt_w'(k) : 3'd2)) begin errors++; $display("FAIL wrap outstanding[%0d]: got %0d", k, bus.outstanding_o); end
            if (k >= 2) begin
                h = q[0];
                checks++; if (bus.mem_resp0_v_o !== (h == 0) || bus.mem_resp1_v_o !== (h == 1)) begin errors++; $display("FAIL wrap resp route[%0d]: got v1v0=%b%b want id %0d", k, bus.mem_resp1_v_o, bus.mem_resp0_v_o, h); end
                void'(q.pop_front());
            end
            q.push_back(int'(p));
        end
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            bus.mem_cmd0_v_i = 1'b0;
            bus.mem_cmd1_v_i = 1'b0;
            bus.mem_resp_v_i = 1'b1;
            #1;
            h = q[0];
            checks++; if (bus.mem_resp0_v_o !== (h == 0) || bus.mem_resp1_v_o !== (h == 1)) begin errors++; $display("FAIL wrap drain route[%0d]: got v1v0=%b%b want id %0d", j, bus.mem_resp1_v_o, bus.mem_resp0_v_o, h); end
            checks++; if (bus.outstanding_o !== cnt_w'(2 - j)) begin errors++; $display("FAIL wrap drain outstanding[%0d]: got %0d want %0d", j, bus.outstanding_o, 2 - j); end
            void'(q.pop_front());
        end
        @(negedge clk);
        idle();
        #1;
        checks++; if (bus.outstanding_o !== 3'd0) begin errors++; $display("FAIL wrap final outstanding: got %0d want 0", bus.outstanding_o); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_cmd0_v_i = 1'b1;
            bus.mem_cmd0_i   = 16'h3000 + 16'(i);
            #1;
            checks++; if (bus.mem_cmd0_ready_and_o !== 1'b1) begin errors++; $display("FAIL areset fill[%0d]: got r0=%b want 1", i, bus.mem_cmd0_ready_and_o); end
        end
        @(negedge clk);
        bus.mem_cmd0_i            = 16'h3003;
        bus.mem_cmd1_v_i          = 1'b1;
        bus.mem_cmd1_i            = 16'h3100;
        bus.mem_cmd_ready_and_i   = 1'b0;
        bus.mem_resp_v_i          = 1'b1;
        bus.mem_resp0_ready_and_i = 1'b0;
        #1;
        checks++; if (bus.mem_resp0_v_o !== 1'b1 || bus.outstanding_o !== 3'd3) begin errors++; $display("FAIL areset before: got v0=%b cnt=%0d want 1 3", bus.mem_resp0_v_o, bus.outstanding_o); end
        #2;
        reset_i = 1'b1;
        #1;
        checks++; if (bus.mem_cmd_v_o !== 1'b0 || bus.mem_resp0_v_o !== 1'b0 || bus.mem_resp1_v_o !== 1'b0) begin errors++; $display("FAIL areset valids: got cmd=%b r0=%b r1=%b want 000", bus.mem_cmd_v_o, bus.mem_resp0_v_o, bus.mem_resp1_v_o); end
        checks++; if (bus.outstanding_o !== 3'd0) begin errors++; $display("FAIL areset outstanding: got %0d want 0", bus.outstanding_o); end
        @(posedge clk);
        @(negedge clk);
        bus.mem_resp_v_i          = 1'b0;
        bus.mem_resp0_ready_and_i = 1'b1;
        bus.mem_cmd_ready_and_i   = 1'b1;
        reset_i = 1'b0;
        #1;
        checks++; if (bus.mem_cmd0_ready_and_o !== 1'b1 || bus.mem_cmd_o !== 16'h3003) begin errors++; $display("FAIL areset first tie: got r0=%b d=%h want 1 3003", bus.mem_cmd0_ready_and_o, bus.mem_cmd_o); end
        @(negedge clk);
        bus.mem_cmd0_v_i = 1'b0;
        #1;
        checks++; if (bus.mem_cmd1_ready_and_o !== 1'b1 || bus.mem_cmd_o !== 16'h3100) begin errors++; $display("FAIL areset second grant: got r1=%b d=%h want 1 3100", bus.mem_cmd1_ready_and_o, bus.mem_cmd_o); end
        @(negedge clk);
        bus.mem_cmd1_v_i = 1'b0;
        bus.mem_resp_v_i = 1'b1;
        #1;
        checks++; if (bus.mem_resp0_v_o !== 1'b1 || bus.outstanding_o !== 3'd2) begin errors++; $display("FAIL areset resp0: got v0=%b cnt=%0d want 1 2", bus.mem_resp0_v_o, bus.outstanding_o); end
        @(negedge clk);
        #1;
        checks++; if (bus.mem_resp1_v_o !== 1'b1 || bus.outstanding_o !== 3'd1) begin errors++; $display("FAIL areset resp1: got v1=%b cnt=%0d want 1 1", bus.mem_resp1_v_o, bus.outstanding_o); end
        @(negedge clk);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure_lock();
        test_full();
        test_push_pop_wrap();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bp_mem_cmd_rr_arbiter.md
# bp_mem_cmd_rr_arbiter

Two-requester round-robin arbiter that shares one BedRock lite memory command/response channel between two cache engines, e.g. an I$ UCE and a D$ UCE in a unicore FE/BE testbench or tile. It arbitrates commands onto a single `mem_cmd` port and records the winner's ID in an in-order tracking FIFO. It then steers each returning `mem_resp` back to the requester at the FIFO head. Memory is assumed to respond in command order; the block enforces a bound on outstanding transactions.

## Interface
- `msg_width_p`, default `cce_mem_msg_width_lp`: width of an opaque lite mem message (header+data); the block never inspects contents.
- `els_p`, default 4: maximum outstanding commands (tracking FIFO depth), ≥1.
- `cnt_width_lp`, localparam `$clog2(els_p+1)`: outstanding counter width.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: reset; one clock; reset is asynchronous and active-high.
- `mem_cmd0_i` in `msg_width_p`: requester 0 command.
- `mem_cmd0_v_i` in 1: requester 0 command valid.
- `mem_cmd0_ready_and_o` out 1: requester 0 command accepted (ready&valid handshake).
- `mem_cmd1_i` in `msg_width_p`: requester 1 command.
- `mem_cmd1_v_i` in 1: requester 1 command valid.
- `mem_cmd1_ready_and_o` out 1: requester 1 command accepted.
- `mem_cmd_o` out `msg_width_p`: arbitrated command to memory.
- `mem_cmd_v_o` out 1: arbitrated command valid.
- `mem_cmd_ready_and_i` in 1: memory ready.
- `mem_resp_i` in `msg_width_p`: response from memory.
- `mem_resp_v_i` in 1: response valid.
- `mem_resp_ready_and_o` out 1: response accepted.
- `mem_resp0_o` out `msg_width_p`: response to requester 0.
- `mem_resp0_v_o` out 1: response to requester 0 valid.
- `mem_resp0_ready_and_i` in 1: requester 0 ready for response.
- `mem_resp1_o` out `msg_width_p`: response to requester 1.
- `mem_resp1_v_o` out 1: response to requester 1 valid.
- `mem_resp1_ready_and_i` in 1: requester 1 ready for response.
- `outstanding_o` out `cnt_width_lp`: current in-flight count (debug/perf).

## Operation
**State**
- `last_r`: last granted ID, 1 bit.
- `lock_r`: grant lock, 1 bit.
- `lock_id_r`: locked grant ID, 1 bit.
- Tracking FIFO: `els_p` × 1-bit IDs, with `rptr`/`wptr`.
- `cnt_r`: outstanding count.

**Full condition:** `full = (cnt_r == els_p)`, computed from registered state only. A response dequeue in the same cycle does not free a slot for a command in that cycle.

**Arbitration**
- If `lock_r` is set, the grant is `lock_id_r`.
- Otherwise, if both requesters are valid, the grant is `~last_r`.
- Otherwise, the grant is the single valid requester.
- With no valid requester, there is no grant.

**Command path**
- `mem_cmd_o` = command of the granted requester.
- `mem_cmd_v_o` = granted requester's valid & `~full`.
- `mem_cmdN_ready_and_o` = (grant==N) & `mem_cmd_ready_and_i` & `~full`.
- A command handshake occurs when `mem_cmd_v_o & mem_cmd_ready_and_i`. On a handshake:
  - push the grant ID into the FIFO;
  - set `last_r` to the grant ID;
  - clear `lock_r`.

**Lock:** if `mem_cmd_v_o & ~mem_cmd_ready_and_i`, set `lock_r=1` and `lock_id_r`=grant. This holds `mem_cmd_o` stable until it is accepted, as the BedRock valid-then-hold rule requires. Requesters must not drop valid once it is asserted.

**Response path**
- Head ID is `h`. The FIFO is empty when `cnt_r==0`.
- `mem_resp{h}_v_o` = `mem_resp_v_i` & `~empty`. The other requester's `_v_o` is 0.
- Both `mem_resp0_o` and `mem_resp1_o` are wired to `mem_resp_i`.
- `mem_resp_ready_and_o` = `~empty` & `mem_resp{h}_ready_and_i`.
- A response handshake pops the FIFO.
- A response arriving while the FIFO is empty is never accepted. The simulation assertion `"unexpected mem_resp"` fires.

**Counter**
- Push only: `cnt_r+1`. Pop only: `cnt_r-1`.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo `els_p`; non-power-of-two depth is supported by an explicit compare-and-reset.

## Timing
- Reset (asynchronous assert) values:
  - `last_r=1`, so requester 0 wins the first tie;
  - `lock_r=0`, `cnt_r=0`, pointers 0;
  - all `_v_o` and `_ready_and_o` outputs are 0 while `reset_i` is high;
  - `outstanding_o=0`.
- Reset mid-transaction discards all tracking. The environment must also reset memory.
- Command path: zero-cycle combinational pass-through from requester to memory. The grant updates on the clock edge after a handshake.
- Response path: zero-cycle combinational steering. A pop takes effect next cycle.
- Back-to-back commands are sustainable at one per cycle while `~full`.
- With both requesters continuously valid, grants alternate 0,1,0,1.
- No combinational path from any `ready_and_i` to any `_v_o`.

## Test plan
- **Single requester:** `cmd0` valid for 3 cycles, mem always ready.
  - Expect 3 handshakes and FIFO ids 0,0,0.
  - Responses A,B,C appear only on `resp0` in order; `outstanding_o` steps 1,2,3 → 0.
- **Contention:** both requesters valid continuously from reset, mem ready, 6 commands.
  - Grant order 0,1,0,1,0,1.
  - Responses route `resp0`, `resp1`, `resp0`, … matching that order.
- **Backpressure lock:** `cmd1` valid, `mem_cmd_ready_and_i=0` for 4 cycles; `cmd0` raised in cycle 2.
  - `mem_cmd_o` stays equal to `cmd1` data until ready.
  - After acceptance, the next grant is 0.
- **Full:** `els_p=4`, 4 commands accepted with no responses.
  - A 5th command sees `ready_and_o=0` and `mem_cmd_v_o=0`, with `outstanding_o=4`.
  - One response pops → next cycle the 5th command is accepted.
- **Simultaneous push/pop at `cnt=2`:**
  - `outstanding_o` stays at 2; pointers advance; ordering is preserved across pointer wrap over 12 transactions.
- **Async reset mid-burst:** assert `reset_i` between edges with 3 outstanding.
  - All `_v_o` drop immediately; `outstanding_o=0`.
  - After release, requester 0 wins the first tie.
